// File: rtl/router_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : router_sync_filter
// Brief    : Per-channel synchroniser, stability filter, edge pulses and
//            sticky event flags for asynchronous router control lines.
// Revision : 1.0 - initial release
// ============================================================================
module router_sync_filter #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STAGES        = 2,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL     = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] filt_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] event_sticky
);

  generate
    if (STAGES < 2) begin : g_stages_check
      $error("router_sync_filter: STAGES must be >= 2");
    end
  endgenerate

  // Plain flop chain: stage 0 is the only flop that sees async_in.
  logic [STAGES-1:0][CHANNELS-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync[0] <= async_in;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign sync_out = r_sync[STAGES-1];

  generate
    if (FILTER_CYCLES > 0) begin : g_filter
      localparam int                 c_cnt_w    = $clog2(FILTER_CYCLES + 1);
      localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_CYCLES - 1);

      logic [CHANNELS-1:0][c_cnt_w-1:0] r_cnt;
      logic [CHANNELS-1:0]              r_filt;

      // Any cycle where the synchronised level agrees with the accepted one
      // restarts the count, so only an unbroken run is accepted.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt  <= '0;
          r_filt <= RESET_VAL;
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (sync_out[i] != r_filt[i]) begin
              if (r_cnt[i] == c_cnt_last) begin
                r_filt[i] <= sync_out[i];
                r_cnt[i]  <= '0;
              end else begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
              end
            end else begin
              r_cnt[i] <= '0;
            end
          end
        end
      end

      assign filt_out = r_filt;
    end else begin : g_bypass
      assign filt_out = sync_out;
    end
  endgenerate

  logic [CHANNELS-1:0] r_filt_prev;
  logic [CHANNELS-1:0] r_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_prev <= RESET_VAL;
    end else begin
      r_filt_prev <= filt_out;
    end
  end

  assign rise_pulse = filt_out & ~r_filt_prev;
  assign fall_pulse = ~filt_out & r_filt_prev;

  // A pulse arriving together with clear still sets the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= rise_pulse | fall_pulse | (r_sticky & ~clear);
    end
  end

  assign event_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_router_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_sync_filter
// Brief    : Self-checking bench for router_sync_filter (filtered and bypass).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_sync_filter;
  localparam int         CH    = 4;
  localparam int         STG_A = 2;
  localparam int         FC_A  = 4;
  localparam int         STG_B = 3;
  localparam logic [3:0] RV_B  = 4'h5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmp_en = 1'b0;
  logic [3:0] async_a, clear_a, async_b, clear_b;
  logic [3:0] sync_a, filt_a, rise_a, fall_a, sticky_a;
  logic [3:0] sync_b, filt_b, rise_b, fall_b, sticky_b;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  router_sync_filter #(
    .CHANNELS(CH), .STAGES(STG_A), .FILTER_CYCLES(FC_A), .RESET_VAL(4'h0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .async_in(async_a), .clear(clear_a),
    .sync_out(sync_a), .filt_out(filt_a), .rise_pulse(rise_a),
    .fall_pulse(fall_a), .event_sticky(sticky_a)
  );

  router_sync_filter #(
    .CHANNELS(CH), .STAGES(STG_B), .FILTER_CYCLES(0), .RESET_VAL(RV_B)
  ) u_dut_b (
    .clk(clk), .rst(rst), .async_in(async_b), .clear(clear_b),
    .sync_out(sync_b), .filt_out(filt_b), .rise_pulse(rise_b),
    .fall_pulse(fall_b), .event_sticky(sticky_b)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Reference for the filtered instance: a delay line of input samples, then
  // a level that flips only after FC_A consecutive disagreeing samples.
  logic [3:0] qa[$];
  logic [3:0] ma_filt, ma_prev, ma_sticky;
  int         ma_run[CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      for (int s = 0; s < STG_A; s++) qa.push_back(4'h0);
      ma_filt   = 4'h0;
      ma_prev   = 4'h0;
      ma_sticky = 4'h0;
      for (int c = 0; c < CH; c++) ma_run[c] = 0;
    end else begin
      ma_sticky = (ma_filt ^ ma_prev) | (ma_sticky & ~clear_a);
      ma_prev   = ma_filt;
      for (int c = 0; c < CH; c++) begin
        if (qa[0][c] != ma_filt[c]) begin
          ma_run[c]++;
          if (ma_run[c] == FC_A) begin
            ma_filt[c] = qa[0][c];
            ma_run[c]  = 0;
          end
        end else begin
          ma_run[c] = 0;
        end
      end
      qa.push_back(async_a);
      void'(qa.pop_front());
    end
  end

  // Reference for the bypass instance: delayed input is the filtered level.
  logic [3:0] qb[$];
  logic [3:0] mb_prev, mb_sticky;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qb.delete();
      for (int s = 0; s < STG_B; s++) qb.push_back(RV_B);
      mb_prev   = RV_B;
      mb_sticky = 4'h0;
    end else begin
      mb_sticky = (qb[0] ^ mb_prev) | (mb_sticky & ~clear_b);
      mb_prev   = qb[0];
      qb.push_back(async_b);
      void'(qb.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #6;
      if (cmp_en) begin
        chk("sync_a", sync_a, qa[0]);
        chk("filt_a", filt_a, ma_filt);
        chk("rise_a", rise_a, ma_filt & ~ma_prev);
        chk("fall_a", fall_a, ~ma_filt & ma_prev);
        chk("sticky_a", sticky_a, ma_sticky);
        chk("sync_b", sync_b, qb[0]);
        chk("filt_b", filt_b, qb[0]);
        chk("rise_b", rise_b, qb[0] & ~mb_prev);
        chk("fall_b", fall_b, ~qb[0] & mb_prev);
        chk("sticky_b", sticky_b, mb_sticky);
      end
    end
  end

  initial begin
    async_a = 4'hF; clear_a = 4'h0;
    async_b = RV_B; clear_b = 4'h0;
    step(1);
    cmp_en = 1'b1;
    step(2);
    // Reset and startup
    chk("rst_sync_a", sync_a, 4'h0);
    chk("rst_filt_a", filt_a, 4'h0);
    chk("rst_pulse_a", rise_a | fall_a, 4'h0);
    chk("rst_sticky_a", sticky_a, 4'h0);
    chk("rst_sync_b", sync_b, 4'h5);
    chk("rst_filt_b", filt_b, 4'h5);
    chk("rst_pulse_b", rise_b | fall_b, 4'h0);
    rst = 1'b0;
    step(1);
    chk("rel_pulse_a", rise_a | fall_a, 4'h0);
    step(1);
    chk("start_sync_a", sync_a, 4'hF);
    chk("start_filt_a_early", filt_a, 4'h0);
    step(4);
    chk("start_filt_a", filt_a, 4'hF);
    chk("start_rise_a", rise_a, 4'hF);
    step(1);
    chk("start_rise_a_end", rise_a, 4'h0);
    chk("start_sticky_a", sticky_a, 4'hF);

    // Bypass latency and coincident pulses
    async_b = 4'hA;
    step(2);
    chk("byp_sync_early", sync_b, 4'h5);
    step(1);
    chk("byp_sync", sync_b, 4'hA);
    chk("byp_filt", filt_b, 4'hA);
    chk("byp_rise", rise_b, 4'hA);
    chk("byp_fall", fall_b, 4'h5);
    step(1);
    chk("byp_rise_end", rise_b, 4'h0);
    chk("byp_sticky", sticky_b, 4'hF);

    // Settle everything low and clear flags
    async_a = 4'h0;
    step(10);
    clear_a = 4'hF;
    step(1);
    clear_a = 4'h0;
    chk("cleared_sticky_a", sticky_a, 4'h0);

    // Glitch of three cycles on channel 0
    async_a[0] = 1'b1;
    step(3);
    async_a[0] = 1'b0;
    step(1);
    chk("glitch_sync0", {3'b0, sync_a[0]}, 4'h1);
    step(10);
    chk("glitch_filt0", {3'b0, filt_a[0]}, 4'h0);
    chk("glitch_sticky0", {3'b0, sticky_a[0]}, 4'h0);

    // Bounce on channel 1: 2 high, 1 low, then held high
    async_a[1] = 1'b1;
    step(2);
    async_a[1] = 1'b0;
    step(1);
    async_a[1] = 1'b1;
    step(5);
    chk("bounce_filt1_early", {3'b0, filt_a[1]}, 4'h0);
    step(1);
    chk("bounce_filt1", {3'b0, filt_a[1]}, 4'h1);
    chk("bounce_rise", rise_a, 4'h2);
    step(1);
    chk("bounce_rise_end", rise_a, 4'h0);

    // Fall on channel 2 colliding with clear
    async_a[2] = 1'b1;
    step(10);
    clear_a = 4'hF;
    step(1);
    clear_a = 4'h0;
    async_a[2] = 1'b0;
    step(6);
    chk("coll_fall2", fall_a, 4'h4);
    clear_a[2] = 1'b1;
    step(1);
    chk("coll_sticky2_set", {3'b0, sticky_a[2]}, 4'h1);
    step(1);
    chk("coll_sticky2_clr", {3'b0, sticky_a[2]}, 4'h0);
    clear_a = 4'h0;

    // Reset while channel 3 is mid-count
    async_a[3] = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    chk("midrst_filt_a", filt_a, 4'h0);
    step(1);
    rst = 1'b0;
    step(5);
    chk("midrst_filt3_early", {3'b0, filt_a[3]}, 4'h0);
    step(1);
    chk("midrst_filt3", {3'b0, filt_a[3]}, 4'h1);

    // Randomised traffic against the models
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 5) == 0) async_a[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) async_b[$urandom_range(0, 3)] ^= 1'b1;
      clear_a = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      clear_b = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
